mem_wb_stage: RTL

MEM/WB pipeline register and writeback select for the 5-stage MIPS core, sitting directly downstream of memoryStage. It consumes readdata, aluRsltt and hit from memoryStage and registers the writeback result for the register file. On a data-memory miss it raises a pipeline stall and inserts bubbles. It tracks miss/stall statistics and flags misses that exceed a timeout.

---
 rtl/mem_wb_stage_if.sv | 39 +++
 rtl/mem_wb_stage.sv | 126 ++++++++++++
 2 files changed

// File: rtl/mem_wb_stage_if.sv
// MEM/WB boundary bundle: inputs from memoryStage plus writeback and
// stall/statistics outputs toward the register file and hazard control.
interface mem_wb_stage_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic                  valid_in;
    logic                  RegWrite;
    logic                  MemtoReg;
    logic                  MemRead;
    logic                  MemWrite;
    logic                  hit;
    logic [DATA_W-1:0]     readdata;
    logic [DATA_W-1:0]     aluRsltt;
    logic [REG_ADDR_W-1:0] writeReg;
    logic                  memStall;
    logic                  wbValid;
    logic                  wbRegWrite;
    logic [REG_ADDR_W-1:0] wbReg;
    logic [DATA_W-1:0]     wbData;
    logic                  missError;
    logic [CNT_W-1:0]      missCount;
    logic [CNT_W-1:0]      stallCycles;

    modport slave (
        input  valid_in, RegWrite, MemtoReg, MemRead, MemWrite, hit,
               readdata, aluRsltt, writeReg,
        output memStall, wbValid, wbRegWrite, wbReg, wbData,
               missError, missCount, stallCycles
    );

    modport master (
        output valid_in, RegWrite, MemtoReg, MemRead, MemWrite, hit,
               readdata, aluRsltt, writeReg,
        input  memStall, wbValid, wbRegWrite, wbReg, wbData,
               missError, missCount, stallCycles
    );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with writeback select, data-miss stall FSM,
// miss timeout detection and saturating miss/stall statistics.
module mem_wb_stage #(
    parameter int DATA_W       = 32,
    parameter int REG_ADDR_W   = 5,
    parameter int MISS_TIMEOUT = 64,
    parameter int CNT_W        = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_wb_stage_if.slave bus
);
    localparam int TMR_W = $clog2(MISS_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(MISS_TIMEOUT);

    typedef enum logic [1:0] {RUN, MISS, ERR} state_t;

    state_t                state_q, state_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic                  wb_valid_q, wb_valid_d;
    logic                  wb_reg_write_q, wb_reg_write_d;
    logic [REG_ADDR_W-1:0] wb_reg_q, wb_reg_d;
    logic [DATA_W-1:0]     wb_data_q, wb_data_d;
    logic                  miss_error_q, miss_error_d;
    logic [CNT_W-1:0]      miss_count_q, miss_count_d;
    logic [CNT_W-1:0]      stall_cycles_q, stall_cycles_d;
    logic                  mem_access;
    logic                  stall;
    logic                  capture;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign mem_access = bus.valid_in & (bus.MemRead | bus.MemWrite);

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        miss_error_d = miss_error_q;
        miss_count_d = miss_count_q;
        stall        = 1'b0;
        capture      = 1'b0;
        case (state_q)
            RUN: begin
                stall = mem_access & ~bus.hit;
                if (stall) begin
                    state_d      = MISS;
                    timer_d      = TMR_W'(1);
                    miss_count_d = sat_inc(miss_count_q);
                end else begin
                    capture = 1'b1;
                end
            end
            MISS: begin
                // Upstream is frozen, so the same instruction is still presented.
                stall = ~bus.hit;
                if (bus.hit) begin
                    capture = 1'b1;
                    state_d = RUN;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                    if (timer_d == TMR_LIMIT) begin
                        state_d      = ERR;
                        miss_error_d = 1'b1;
                    end
                end
            end
            ERR: begin
                stall = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        stall_cycles_d = stall ? sat_inc(stall_cycles_q) : stall_cycles_q;

        if (capture) begin
            wb_valid_d     = bus.valid_in;
            wb_reg_write_d = bus.valid_in & bus.RegWrite & (bus.writeReg != '0);
            wb_reg_d       = bus.writeReg;
            wb_data_d      = bus.MemtoReg ? bus.readdata : bus.aluRsltt;
        end else begin
            wb_valid_d     = 1'b0;
            wb_reg_write_d = 1'b0;
            wb_reg_d       = wb_reg_q;
            wb_data_d      = wb_data_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= RUN;
            timer_q        <= '0;
            wb_valid_q     <= 1'b0;
            wb_reg_write_q <= 1'b0;
            wb_reg_q       <= '0;
            wb_data_q      <= '0;
            miss_error_q   <= 1'b0;
            miss_count_q   <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            wb_valid_q     <= wb_valid_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_reg_q       <= wb_reg_d;
            wb_data_q      <= wb_data_d;
            miss_error_q   <= miss_error_d;
            miss_count_q   <= miss_count_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    // Stall is forced low while reset is held so upstream is never frozen.
    assign bus.memStall    = rst_n & stall;
    assign bus.wbValid     = wb_valid_q;
    assign bus.wbRegWrite  = wb_reg_write_q;
    assign bus.wbReg       = wb_reg_q;
    assign bus.wbData      = wb_data_q;
    assign bus.missError   = miss_error_q;
    assign bus.missCount   = miss_count_q;
    assign bus.stallCycles = stall_cycles_q;
endmodule
